// File: rtl/rv32_pkg.sv
// rv32_pkg: shared RV32I store opcode, func3 and store FSM state encodings
package rv32_pkg;
  localparam logic [6:0] OPCODE_STORE = 7'b0100011;
  localparam logic [2:0] F3_SB = 3'd0;
  localparam logic [2:0] F3_SH = 3'd1;
  localparam logic [2:0] F3_SW = 3'd2;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_MERGE = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
endpackage

// File: rtl/store_merge.sv
// store_merge: inserts the SB/SH lane of rs2 into an old RAM word (SW passes rs2)
module store_merge
  import rv32_pkg::*;
(
  input  logic [31:0] oldWord,
  input  logic [31:0] rs2,
  input  logic [1:0]  lane,
  input  logic [2:0]  func3,
  output logic [31:0] merged
);
  always_comb begin
    merged = oldWord;
    if (func3 == F3_SB) merged[{lane, 3'b000} +: 8] = rs2[7:0];
    else if (func3 == F3_SH) merged[{lane[1], 4'b0000} +: 16] = rs2[15:0];
    else merged = rs2;
  end
endmodule

// File: rtl/store_unit.sv
// store_unit: RV32I SB/SH/SW executor; sub-word stores do read-modify-write on a word RAM
module store_unit
  import rv32_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int XLEN   = 32
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iSTART,
  input  logic [31:0]       iIR,
  input  logic [XLEN-1:0]   iREG_OUT1,
  input  logic [XLEN-1:0]   iREG_OUT2,
  output logic [4:0]        oRS1,
  output logic [4:0]        oRS2,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR,
  output logic              oRAM_CE,
  output logic              oRAM_RD,
  output logic              oRAM_WR,
  output logic [ADDR_W-1:0] oRAM_ADDR,
  output logic [XLEN-1:0]   oRAM_DATA,
  input  logic [XLEN-1:0]   iRAM_DATA
);
  logic [2:0]        state;
  logic [ADDR_W+1:0] eaR, ea;
  logic [2:0]        f3R, f3;
  logic [XLEN-1:0]   dataR, mergedR, mergeOut, imm;
  logic              errR, err;
  assign oRS1 = iIR[19:15];
  assign oRS2 = iIR[24:20];
  assign f3   = iIR[14:12];
  assign imm  = {{(XLEN-12){iIR[31]}}, iIR[31:25], iIR[11:7]};
  // only the word-address and lane bits of the effective address matter downstream
  assign ea   = (ADDR_W+2)'(iREG_OUT1 + imm);
  assign err  = iIR[6:0] != OPCODE_STORE || f3 > F3_SW
             || (f3 == F3_SH && ea[0]) || (f3 == F3_SW && ea[1:0] != 2'b00);
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state   <= S_IDLE;
      eaR     <= '0;
      f3R     <= '0;
      dataR   <= '0;
      mergedR <= '0;
      errR    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (iSTART) begin
          eaR   <= ea;
          f3R   <= f3;
          dataR <= iREG_OUT2;
          errR  <= err;
          state <= err ? S_DONE : f3 == F3_SW ? S_WRITE : S_READ;
        end
        S_READ:  state <= S_MERGE;
        S_MERGE: begin
          mergedR <= mergeOut;
          state   <= S_WRITE;
        end
        S_WRITE: state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end
  store_merge uMerge (
    .oldWord(iRAM_DATA),
    .rs2    (dataR),
    .lane   (eaR[1:0]),
    .func3  (f3R),
    .merged (mergeOut)
  );
  assign oBUSY     = state != S_IDLE;
  assign oDONE     = state == S_DONE;
  assign oERR      = oDONE & errR;
  assign oRAM_RD   = state == S_READ;
  assign oRAM_WR   = state == S_WRITE;
  assign oRAM_CE   = oRAM_RD | oRAM_WR;
  assign oRAM_ADDR = oRAM_CE ? eaR[ADDR_W+1:2] : '0;
  assign oRAM_DATA = oRAM_WR ? (f3R == F3_SW ? dataR : mergedR) : '0;
endmodule
